// File: rtl/sys_bus_arb_pkg.sv
// rtl/sys_bus_arb_pkg.sv - shared types and helpers for the system bus arbiter
package sys_bus_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Timeout counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  // First pending index at or after ptr. Bits above NUM_REQ are zero, so a
  // modulo-8 scan gives the same order as a modulo-NUM_REQ scan.
  function automatic logic [IDX_W-1:0] next_rr(input logic [MAX_REQ-1:0] pending,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sys_req_latch.sv
// rtl/sys_req_latch.sv - per-requester pulse capture with pending and overflow flags
module sys_req_latch
  import sys_bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  axi_clk_i,
  input  logic                  axi_rstn_i,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic                  serve,
  output logic                  pending,
  output logic                  ovf,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [DATA_WIDTH-1:0] wdata_q,
  output logic [SEL_WIDTH-1:0]  sel_q,
  output op_e                   op_q
);

  // Latch a new request only when idle; a pulse while pending is dropped and flagged.
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      pending <= 1'b0;
      ovf     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      op_q    <= OP_RD;
    end else begin
      if (wen || ren) begin
        if (pending) begin
          ovf <= 1'b1;
        end else begin
          pending <= 1'b1;
          addr_q  <= addr;
          wdata_q <= wdata;
          sel_q   <= sel;
          op_q    <= wen ? OP_WR : OP_RD;
        end
      end
      if (serve) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// rtl/sys_bus_arbiter.sv - round-robin arbiter sharing one system bus among NUM_REQ masters
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                             axi_clk_i,
  input  logic                             axi_rstn_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ*(ADDR_WIDTH/8)-1:0] req_sel_i,
  input  logic [NUM_REQ-1:0]               req_wen_i,
  input  logic [NUM_REQ-1:0]               req_ren_i,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    req_rdata_o,
  output logic [NUM_REQ-1:0]               req_err_o,
  output logic [NUM_REQ-1:0]               req_ack_o,
  output logic [ADDR_WIDTH-1:0]            sys_addr_o,
  output logic [DATA_WIDTH-1:0]            sys_wdata_o,
  output logic [ADDR_WIDTH/8-1:0]          sys_sel_o,
  output logic                             sys_wen_o,
  output logic                             sys_ren_o,
  input  logic [DATA_WIDTH-1:0]            sys_rdata_i,
  input  logic                             sys_err_i,
  input  logic                             sys_ack_i,
  output logic [NUM_REQ-1:0]               ovf_o
);

  localparam int SEL_W = ADDR_WIDTH / 8;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [NUM_REQ-1:0]    pending;
  logic [ADDR_WIDTH-1:0] lat_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] lat_wdata [NUM_REQ];
  logic [SEL_W-1:0]      lat_sel   [NUM_REQ];
  op_e                   lat_op    [NUM_REQ];

  state_e           state;
  state_e           state_nxt;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  op_e              cur_op;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic [SEL_W-1:0]      pick_sel;
  op_e                   pick_op;

  logic                  resp_load;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    sys_req_latch #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_W)
    ) u_latch (
      .axi_clk_i  (axi_clk_i),
      .axi_rstn_i (axi_rstn_i),
      .wen        (req_wen_i[i]),
      .ren        (req_ren_i[i]),
      .addr       (req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata      (req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .sel        (req_sel_i[i*SEL_W +: SEL_W]),
      .serve      (req_ack_o[i]),
      .pending    (pending[i]),
      .ovf        (ovf_o[i]),
      .addr_q     (lat_addr[i]),
      .wdata_q    (lat_wdata[i]),
      .sel_q      (lat_sel[i]),
      .op_q       (lat_op[i])
    );
  end

  // Round-robin pick, the winner's payload, and the response value to return.
  always_comb begin
    pick       = next_rr(MAX_REQ'(pending), ptr);
    pick_addr  = '0;
    pick_wdata = '0;
    pick_sel   = '0;
    pick_op    = OP_RD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_addr  = lat_addr[i];
        pick_wdata = lat_wdata[i];
        pick_sel   = lat_sel[i];
        pick_op    = lat_op[i];
      end
    end
    timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES));
    resp_load   = ((state == ISSUE) && sys_ack_i) ||
                  ((state == WAIT) && (sys_ack_i || timeout_hit));
    resp_rdata  = sys_ack_i ? sys_rdata_i : '0;
    resp_err    = sys_ack_i ? sys_err_i : 1'b1;
  end

  // Next state plus the state-decoded strobes towards both sides.
  always_comb begin
    state_nxt = state;
    sys_wen_o = 1'b0;
    sys_ren_o = 1'b0;
    req_ack_o = '0;
    case (state)
      IDLE: begin
        if (|pending) state_nxt = ISSUE;
      end
      ISSUE: begin
        sys_wen_o = (cur_op == OP_WR);
        sys_ren_o = (cur_op == OP_RD);
        state_nxt = sys_ack_i ? RESP : WAIT;
      end
      WAIT: begin
        if (sys_ack_i || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        req_ack_o = NUM_REQ'(1) << grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, grant/pointer bookkeeping, downstream payload and timeout counter.
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= '0;
      cur_op      <= OP_RD;
      cnt         <= '0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant      <= pick;
            ptr        <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
            cur_op     <= pick_op;
            sys_addr_o <= pick_addr;
            sys_sel_o  <= pick_sel;
            if (pick_op == OP_WR) sys_wdata_o <= pick_wdata;
          end
        end
        ISSUE: cnt <= CNT_W'(1);
        WAIT: begin
          if (!sys_ack_i && !timeout_hit) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Completion result goes only into the granted requester's slice; others hold.
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      req_rdata_o <= '0;
      req_err_o   <= '0;
    end else if (resp_load) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == IDX_W'(i)) begin
          req_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] <= resp_rdata;
          req_err_o[i]                            <= resp_err;
        end
      end
    end
  end

endmodule
